dtpu_weight_loader: RTL

//  Sequences weight-memory reads that fill the MXU weight registers with one tile (ROWS words).

---
 rtl/dtpu_weight_loader_pkg.sv | 17 +
 rtl/dtpu_weight_loader_if.sv | 30 +++
 rtl/dtpu_weight_loader.sv | 118 +++++++++++
 3 files changed

// File: rtl/dtpu_weight_loader_pkg.sv
// Shared types for the DTPU weight loader.
package dtpu_weight_loader_pkg;

  // Loader sequencer states; encodings are fixed so they match the control-unit view.
  typedef enum logic [1:0] {
    WlIdle  = 2'd0,
    WlIssue = 2'd1,
    WlDrain = 2'd2,
    WlDone  = 2'd3
  } wl_state_e;

  // Width of a row index for a tile of the given height (at least one bit).
  function automatic int unsigned row_width(int unsigned rows);
    return (rows > 1) ? $clog2(rows) : 1;
  endfunction

endpackage

// File: rtl/dtpu_weight_loader_if.sv
// Weight BRAM read port plus MXU weight-register load bus.
interface dtpu_weight_loader_if
  import dtpu_weight_loader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH_WMEMORY = 64,
  parameter int unsigned ROWS               = 8,
  parameter int unsigned ADDR_WIDTH         = 32
);
  localparam int unsigned RowW = row_width(ROWS);

  logic [ADDR_WIDTH-1:0]         wm_address;
  logic                          wm_ce;
  logic                          wm_we;
  logic [DATA_WIDTH_WMEMORY-1:0] wm_dout;
  logic                          w_load;
  logic [RowW-1:0]               w_row;
  logic [DATA_WIDTH_WMEMORY-1:0] w_data;

  // Loader side: drives memory requests and MXU loads, receives read data.
  modport master (
    output wm_address, wm_ce, wm_we, w_load, w_row, w_data,
    input  wm_dout
  );

  // Memory/MXU side.
  modport slave (
    input  wm_address, wm_ce, wm_we, w_load, w_row, w_data,
    output wm_dout
  );
endinterface

// File: rtl/dtpu_weight_loader.sv
// Fetches one tile (ROWS consecutive words) from weight memory into the MXU weight registers
// per start, then advances the tile base, wrapping to 0 when the next tile would not fit.
module dtpu_weight_loader
  import dtpu_weight_loader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH_WMEMORY = 64,
  parameter int unsigned ROWS               = 8,
  parameter int unsigned SIZE_WMEMORY       = 2048,
  parameter int unsigned ADDR_WIDTH         = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  restart,
  output logic                  busy,
  output logic                  done,
  output logic                  wrapped,
  output logic [ADDR_WIDTH-1:0] tile_base,
  dtpu_weight_loader_if.master  wl
);
  localparam int unsigned          RowW    = row_width(ROWS);
  localparam logic [RowW-1:0]       LastCnt = RowW'(ROWS - 1);
  localparam logic [ADDR_WIDTH-1:0] RowsA   = ADDR_WIDTH'(ROWS);
  localparam logic [ADDR_WIDTH-1:0] SizeA   = ADDR_WIDTH'(SIZE_WMEMORY);

  wl_state_e             state_q, state_d;
  logic [RowW-1:0]       cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] tile_base_q, tile_base_d;
  logic                  rd_pend_q;
  logic [RowW-1:0]       row_q;
  logic                  issue;
  logic                  done_c;
  logic                  wrap_c;

  // Sequencer state, row counter and tile base.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= WlIdle;
      cnt_q       <= '0;
      tile_base_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tile_base_q <= tile_base_d;
    end
  end

  // Next state, issue strobe and tile-base advance.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tile_base_d = tile_base_q;
    issue       = 1'b0;
    done_c      = 1'b0;
    wrap_c      = 1'b0;
    case (state_q)
      WlIdle: begin
        // restart and start together: base cleared on the same edge the load begins.
        if (restart) tile_base_d = '0;
        if (start) begin
          state_d = WlIssue;
          cnt_d   = '0;
        end
      end
      WlIssue: begin
        issue = 1'b1;
        cnt_d = cnt_q + RowW'(1);
        if (cnt_q == LastCnt) state_d = WlDrain;
      end
      WlDrain: state_d = WlDone;
      WlDone: begin
        state_d = WlIdle;
        done_c  = 1'b1;
        if (tile_base_q + (RowsA << 1) > SizeA) begin
          tile_base_d = '0;
          wrap_c      = 1'b1;
        end else begin
          tile_base_d = tile_base_q + RowsA;
        end
      end
      default: state_d = WlIdle;
    endcase
    // Abort: back to idle with base cleared and no completion reported.
    if (restart && (state_q != WlIdle)) begin
      state_d     = WlIdle;
      tile_base_d = '0;
      done_c      = 1'b0;
      wrap_c      = 1'b0;
    end
  end

  // One-stage read pipeline matching the BRAM's single-cycle latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_pend_q <= 1'b0;
      row_q     <= '0;
    end else begin
      // A read issued in the abort cycle is dropped so no beat follows the restart.
      rd_pend_q <= issue & ~restart;
      row_q     <= cnt_q;
    end
  end

  // Output decode.
  always_comb begin
    busy          = (state_q != WlIdle);
    done          = done_c;
    wrapped       = wrap_c;
    tile_base     = tile_base_q;
    wl.wm_ce      = issue;
    wl.wm_we      = 1'b0;
    wl.wm_address = issue ? (tile_base_q + ADDR_WIDTH'(cnt_q)) : '0;
    wl.w_load     = rd_pend_q;
    wl.w_row      = row_q;
    wl.w_data     = rd_pend_q ? wl.wm_dout : '0;
  end

endmodule
